// File: rtl/axis_pkg.sv
// axis_pkg -- shared definitions for the 2:1 round-robin AXI-Stream arbiter.
//   arb_state_t        : arbiter FSM state encoding (IDLE / GRANT0 / GRANT1)
//   MAX_BEATS_DEFAULT  : default packet length limit before forced termination
//   CNT_W              : width of the beat and packet counters
//   grant_state()      : maps a requester index to its GRANT state
package axis_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } arb_state_t;

  localparam int MAX_BEATS_DEFAULT = 256;
  localparam int CNT_W             = 16;

  function automatic arb_state_t grant_state(input logic req);
    return req ? ST_GRANT1 : ST_GRANT0;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// axis_out_reg -- single-entry AXI-Stream output register slice.
// Ports:
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   in_valid            : a beat is being accepted this cycle (already qualified by in_ready)
//   in_data, in_last    : payload and last flag of the accepted beat
//   in_ready            : the slice can take a beat this cycle (empty, or draining now)
//   m_tdata/m_tvalid/m_tlast, m_tready : registered AXI-Stream master side
module axis_out_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready
);

  logic [DATA_W-1:0] tdata_reg;
  logic              tvalid_reg;
  logic              tlast_reg;

  // Accepting while the held beat drains keeps full throughput with one register.
  assign in_ready = !tvalid_reg || m_tready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tdata_reg  <= '0;
      tvalid_reg <= 1'b0;
      tlast_reg  <= 1'b0;
    end else if (in_valid) begin
      tdata_reg  <= in_data;
      tlast_reg  <= in_last;
      tvalid_reg <= 1'b1;
    end else if (m_tready) begin
      // Payload is left as-is; only valid drops once the beat is taken.
      tvalid_reg <= 1'b0;
    end
  end

  assign m_tdata  = tdata_reg;
  assign m_tvalid = tvalid_reg;
  assign m_tlast  = tlast_reg;

endmodule

// File: rtl/axis_rr_arb_2_1.sv
// axis_rr_arb_2_1 -- packet-level round-robin arbiter, two AXI-Stream sources
// into one registered AXI-Stream output.
// Ports:
//   clk, reset                 : rising-edge clock, asynchronous active-high reset
//   s0_* / s1_*                : requester streams (tdata, tvalid, tlast in; tready out)
//   m_tdata/m_tvalid/m_tlast   : registered output stream, m_tready from downstream
//   sel                        : current or most recent grant (0 = s0, 1 = s1)
//   busy                       : a packet is in progress
//   pkt_cnt0 / pkt_cnt1        : completed packets per requester (wrapping)
//   err_oversize               : sticky, some packet was cut at MAX_BEATS
module axis_rr_arb_2_1
  import axis_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = MAX_BEATS_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s0_tdata,
  input  logic              s0_tvalid,
  input  logic              s0_tlast,
  output logic              s0_tready,
  input  logic [DATA_W-1:0] s1_tdata,
  input  logic              s1_tvalid,
  input  logic              s1_tlast,
  output logic              s1_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic              sel,
  output logic              busy,
  output logic [15:0]       pkt_cnt0,
  output logic [15:0]       pkt_cnt1,
  output logic              err_oversize
);

  arb_state_t        state_reg;
  arb_state_t        state_next;
  logic              rr_ptr_reg;
  logic              sel_reg;
  logic [CNT_W-1:0]  beat_cnt_reg;
  logic [CNT_W-1:0]  pkt_cnt0_reg;
  logic [CNT_W-1:0]  pkt_cnt1_reg;
  logic              err_oversize_reg;

  logic              out_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic              in_accept;
  logic              at_max;
  logic              pkt_end;
  logic              force_end;

  // 2:1 payload select. sel_reg equals the granted requester in both GRANT
  // states, so the select is correct whenever a beat can be accepted.
  assign in_data   = sel_reg ? s1_tdata  : s0_tdata;
  assign in_valid  = sel_reg ? s1_tvalid : s0_tvalid;
  assign in_last   = sel_reg ? s1_tlast  : s0_tlast;
  assign in_ready  = sel_reg ? s1_tready : s0_tready;
  assign in_accept = in_valid && in_ready;

  // The beat that would make the packet MAX_BEATS long always closes it.
  assign at_max    = (beat_cnt_reg == CNT_W'(MAX_BEATS - 1));
  assign pkt_end   = in_accept && (in_last || at_max);
  assign force_end = in_accept && at_max && !in_last;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (s0_tvalid && s1_tvalid) begin
          // Contention goes to the requester that was not served last.
          state_next = grant_state(!rr_ptr_reg);
        end else if (s0_tvalid) begin
          state_next = ST_GRANT0;
        end else if (s1_tvalid) begin
          state_next = ST_GRANT1;
        end
      end
      ST_GRANT0,
      ST_GRANT1: begin
        // Grant is held until the packet ends, even across tvalid gaps.
        if (pkt_end) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    s0_tready = 1'b0;
    s1_tready = 1'b0;
    busy      = 1'b0;
    case (state_reg)
      ST_GRANT0: begin
        s0_tready = out_ready;
        busy      = 1'b1;
      end
      ST_GRANT1: begin
        s1_tready = out_ready;
        busy      = 1'b1;
      end
      default: begin
        s0_tready = 1'b0;
        s1_tready = 1'b0;
        busy      = 1'b0;
      end
    endcase
  end

  // ---------------- grant bookkeeping and status counters ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_reg       <= 1'b1;
      sel_reg          <= 1'b0;
      beat_cnt_reg     <= '0;
      pkt_cnt0_reg     <= '0;
      pkt_cnt1_reg     <= '0;
      err_oversize_reg <= 1'b0;
    end else begin
      if ((state_reg == ST_IDLE) && (state_next != ST_IDLE)) begin
        sel_reg <= (state_next == ST_GRANT1);
      end

      if (pkt_end) begin
        beat_cnt_reg <= '0;
        rr_ptr_reg   <= sel_reg;
        if (sel_reg) begin
          pkt_cnt1_reg <= pkt_cnt1_reg + CNT_W'(1);
        end else begin
          pkt_cnt0_reg <= pkt_cnt0_reg + CNT_W'(1);
        end
      end else if (in_accept) begin
        beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
      end

      if (force_end) begin
        err_oversize_reg <= 1'b1;
      end
    end
  end

  // A forced end is marked on the output so downstream sees a closed packet.
  axis_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_accept),
    .in_data  (in_data),
    .in_last  (in_last || at_max),
    .in_ready (out_ready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tready (m_tready)
  );

  assign sel          = sel_reg;
  assign pkt_cnt0     = pkt_cnt0_reg;
  assign pkt_cnt1     = pkt_cnt1_reg;
  assign err_oversize = err_oversize_reg;

endmodule

// File: tb/tb_axis_rr_arb_2_1.sv
// Directed testbench for axis_rr_arb_2_1 (instantiated with MAX_BEATS = 4).
// Source queues feed the s0/s1 ports; a monitor collects every output beat.
// Inputs change 1 ns after the rising edge, outputs are sampled on the falling edge.
module tb_axis_rr_arb_2_1;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  s0_tdata = '0;
  logic        s0_tvalid = 1'b0;
  logic        s0_tlast = 1'b0;
  logic        s0_tready;
  logic [7:0]  s1_tdata = '0;
  logic        s1_tvalid = 1'b0;
  logic        s1_tlast = 1'b0;
  logic        s1_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready = 1'b0;
  logic        sel;
  logic        busy;
  logic [15:0] pkt_cnt0;
  logic [15:0] pkt_cnt1;
  logic        err_oversize;

  int    n_checks = 0;
  int    n_pass = 0;
  beat_t q0[$];
  beat_t q1[$];
  beat_t out_q[$];
  logic  s0_acc = 1'b0;
  logic  s1_acc = 1'b0;

  axis_rr_arb_2_1 #(
    .DATA_W    (8),
    .MAX_BEATS (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s0_tdata     (s0_tdata),
    .s0_tvalid    (s0_tvalid),
    .s0_tlast     (s0_tlast),
    .s0_tready    (s0_tready),
    .s1_tdata     (s1_tdata),
    .s1_tvalid    (s1_tvalid),
    .s1_tlast     (s1_tlast),
    .s1_tready    (s1_tready),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tlast      (m_tlast),
    .m_tready     (m_tready),
    .sel          (sel),
    .busy         (busy),
    .pkt_cnt0     (pkt_cnt0),
    .pkt_cnt1     (pkt_cnt1),
    .err_oversize (err_oversize)
  );

  always #5 clk = ~clk;

  function automatic beat_t mk(input logic [7:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    return b;
  endfunction

  // Monitor: a handshake seen at the falling edge completes on the next rising edge.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      s0_acc = s0_tvalid && s0_tready;
      s1_acc = s1_tvalid && s1_tready;
      if (m_tvalid && m_tready) begin
        b.data = m_tdata;
        b.last = m_tlast;
        out_q.push_back(b);
        $display("[%0t] out beat data=%h last=%b sel=%b", $time, m_tdata, m_tlast, sel);
      end
    end
  end

  // Source drivers: retire the accepted head, then present the next one.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (s0_acc && q0.size() > 0) q0.delete(0);
      if (s1_acc && q1.size() > 0) q1.delete(0);
      if (q0.size() > 0) begin
        s0_tvalid = 1'b1; s0_tdata = q0[0].data; s0_tlast = q0[0].last;
      end else begin
        s0_tvalid = 1'b0; s0_tdata = '0; s0_tlast = 1'b0;
      end
      if (q1.size() > 0) begin
        s1_tvalid = 1'b1; s1_tdata = q1[0].data; s1_tlast = q1[0].last;
      end else begin
        s1_tvalid = 1'b0; s1_tdata = '0; s1_tlast = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    q0.delete();
    q1.delete();
    repeat (2) step();
    reset = 1'b0;
    out_q.delete();
  endtask

  task automatic wait_drain(input string name, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (q0.size() == 0 && q1.size() == 0 && !m_tvalid && !busy) begin
        done = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!done) $display("FAIL %s_drain: still busy after %0d cycles, required idle", name, budget);
    else n_pass++;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++; if (m_tvalid !== 1'b0) $display("FAIL reset_m_tvalid: got %b want 0", m_tvalid); else n_pass++;
    n_checks++; if (m_tdata !== 8'h00) $display("FAIL reset_m_tdata: got %h want 00", m_tdata); else n_pass++;
    n_checks++; if (m_tlast !== 1'b0) $display("FAIL reset_m_tlast: got %b want 0", m_tlast); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (sel !== 1'b0) $display("FAIL reset_sel: got %b want 0", sel); else n_pass++;
    n_checks++; if ({s0_tready, s1_tready} !== 2'b00) $display("FAIL reset_tready: got %b want 00", {s0_tready, s1_tready}); else n_pass++;
    n_checks++; if (pkt_cnt0 !== 16'h0000) $display("FAIL reset_pkt_cnt0: got %h want 0000", pkt_cnt0); else n_pass++;
    n_checks++; if (pkt_cnt1 !== 16'h0000) $display("FAIL reset_pkt_cnt1: got %h want 0000", pkt_cnt1); else n_pass++;
    n_checks++; if (err_oversize !== 1'b0) $display("FAIL reset_err: got %b want 0", err_oversize); else n_pass++;
    step();
    reset = 1'b0;
  endtask

  task automatic test_basic();
    beat_t exp_b[$];
    step();
    m_tready = 1'b1;
    q0.push_back(mk(8'h11, 1'b0));
    q0.push_back(mk(8'h22, 1'b0));
    q0.push_back(mk(8'h33, 1'b1));
    exp_b = q0;
    @(negedge clk);
    @(negedge clk); #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL basic_lat_idle: busy got %b want 0", busy); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if ({busy, s0_tready, s1_tready, m_tvalid} !== 4'b1100) $display("FAIL basic_lat_grant: busy/t0/t1/mv got %b want 1100", {busy, s0_tready, s1_tready, m_tvalid}); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if ({m_tvalid, m_tdata} !== {1'b1, 8'h11}) $display("FAIL basic_lat_first: got %b/%h want 1/11", m_tvalid, m_tdata); else n_pass++;
    wait_drain("basic", 50);
    n_checks++; if (out_q.size() !== exp_b.size()) $display("FAIL basic_count: got %0d beats want %0d", out_q.size(), exp_b.size()); else n_pass++;
    foreach (exp_b[i]) begin
      n_checks++;
      if (i >= out_q.size()) $display("FAIL basic_beat%0d: missing, want %h/%b", i, exp_b[i].data, exp_b[i].last);
      else if (out_q[i] !== exp_b[i]) $display("FAIL basic_beat%0d: got %h/%b want %h/%b", i, out_q[i].data, out_q[i].last, exp_b[i].data, exp_b[i].last);
      else n_pass++;
    end
    n_checks++; if ({pkt_cnt0, pkt_cnt1} !== {16'd1, 16'd0}) $display("FAIL basic_pkt_cnt: got %0d/%0d want 1/0", pkt_cnt0, pkt_cnt1); else n_pass++;
    n_checks++; if (sel !== 1'b0) $display("FAIL basic_sel: got %b want 0", sel); else n_pass++;
  endtask

  task automatic test_round_robin();
    beat_t exp_b[$];
    do_reset();
    m_tready = 1'b1;
    q0.push_back(mk(8'hA1, 1'b0)); q0.push_back(mk(8'hA2, 1'b1));
    q0.push_back(mk(8'hA3, 1'b0)); q0.push_back(mk(8'hA4, 1'b1));
    q1.push_back(mk(8'hB1, 1'b0)); q1.push_back(mk(8'hB2, 1'b1));
    q1.push_back(mk(8'hB3, 1'b0)); q1.push_back(mk(8'hB4, 1'b1));
    exp_b = '{mk(8'hA1, 1'b0), mk(8'hA2, 1'b1), mk(8'hB1, 1'b0), mk(8'hB2, 1'b1),
              mk(8'hA3, 1'b0), mk(8'hA4, 1'b1), mk(8'hB3, 1'b0), mk(8'hB4, 1'b1)};
    wait_drain("rr", 100);
    n_checks++; if (out_q.size() !== exp_b.size()) $display("FAIL rr_count: got %0d beats want %0d", out_q.size(), exp_b.size()); else n_pass++;
    foreach (exp_b[i]) begin
      n_checks++;
      if (i >= out_q.size()) $display("FAIL rr_beat%0d: missing, want %h/%b", i, exp_b[i].data, exp_b[i].last);
      else if (out_q[i] !== exp_b[i]) $display("FAIL rr_beat%0d: got %h/%b want %h/%b", i, out_q[i].data, out_q[i].last, exp_b[i].data, exp_b[i].last);
      else n_pass++;
    end
    n_checks++; if ({pkt_cnt0, pkt_cnt1} !== {16'd2, 16'd2}) $display("FAIL rr_pkt_cnt: got %0d/%0d want 2/2", pkt_cnt0, pkt_cnt1); else n_pass++;
    n_checks++; if (sel !== 1'b1) $display("FAIL rr_sel: got %b want 1", sel); else n_pass++;
  endtask

  task automatic test_backpressure();
    beat_t exp_b[$];
    bit seen = 1'b0;
    out_q.delete();
    m_tready = 1'b1;
    q0.push_back(mk(8'hC1, 1'b0)); q0.push_back(mk(8'hC2, 1'b0)); q0.push_back(mk(8'hC3, 1'b1));
    exp_b = q0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (out_q.size() >= 1) begin seen = 1'b1; break; end
    end
    n_checks++; if (!seen) $display("FAIL bp_first_beat: no output within 20 cycles, required 1 beat"); else n_pass++;
    step();
    m_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      n_checks++; if ({m_tvalid, m_tdata} !== {1'b1, 8'hC2}) $display("FAIL bp_hold%0d: got %b/%h want 1/c2", k, m_tvalid, m_tdata); else n_pass++;
      n_checks++; if (s0_tready !== 1'b0) $display("FAIL bp_tready%0d: got %b want 0", k, s0_tready); else n_pass++;
    end
    step();
    m_tready = 1'b1;
    wait_drain("bp", 50);
    n_checks++; if (out_q.size() !== exp_b.size()) $display("FAIL bp_count: got %0d beats want %0d", out_q.size(), exp_b.size()); else n_pass++;
    foreach (exp_b[i]) begin
      n_checks++;
      if (i >= out_q.size()) $display("FAIL bp_beat%0d: missing, want %h/%b", i, exp_b[i].data, exp_b[i].last);
      else if (out_q[i] !== exp_b[i]) $display("FAIL bp_beat%0d: got %h/%b want %h/%b", i, out_q[i].data, out_q[i].last, exp_b[i].data, exp_b[i].last);
      else n_pass++;
    end
    n_checks++; if (pkt_cnt0 !== 16'd3) $display("FAIL bp_pkt_cnt0: got %0d want 3", pkt_cnt0); else n_pass++;
  endtask

  task automatic test_oversize();
    beat_t exp_b[$];
    do_reset();
    m_tready = 1'b1;
    for (int i = 1; i <= 6; i++) q1.push_back(mk(8'hD0 + 8'(i), (i == 6)));
    exp_b = '{mk(8'hD1, 1'b0), mk(8'hD2, 1'b0), mk(8'hD3, 1'b0), mk(8'hD4, 1'b1),
              mk(8'hD5, 1'b0), mk(8'hD6, 1'b1)};
    wait_drain("ovs", 60);
    n_checks++; if (out_q.size() !== exp_b.size()) $display("FAIL ovs_count: got %0d beats want %0d", out_q.size(), exp_b.size()); else n_pass++;
    foreach (exp_b[i]) begin
      n_checks++;
      if (i >= out_q.size()) $display("FAIL ovs_beat%0d: missing, want %h/%b", i, exp_b[i].data, exp_b[i].last);
      else if (out_q[i] !== exp_b[i]) $display("FAIL ovs_beat%0d: got %h/%b want %h/%b", i, out_q[i].data, out_q[i].last, exp_b[i].data, exp_b[i].last);
      else n_pass++;
    end
    n_checks++; if (err_oversize !== 1'b1) $display("FAIL ovs_err: got %b want 1", err_oversize); else n_pass++;
    n_checks++; if ({pkt_cnt0, pkt_cnt1} !== {16'd0, 16'd2}) $display("FAIL ovs_pkt_cnt: got %0d/%0d want 0/2", pkt_cnt0, pkt_cnt1); else n_pass++;
  endtask

  task automatic test_reset_mid();
    beat_t exp_b[$];
    bit seen = 1'b0;
    do_reset();
    m_tready = 1'b0;
    q1.push_back(mk(8'hE1, 1'b0)); q1.push_back(mk(8'hE2, 1'b0)); q1.push_back(mk(8'hE3, 1'b1));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (m_tvalid) begin seen = 1'b1; break; end
    end
    n_checks++; if (!seen || {busy, sel} !== 2'b11) $display("FAIL rmid_setup: m_tvalid seen=%b busy/sel=%b want 1 and 11", seen, {busy, sel}); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if ({m_tvalid, busy, s1_tready} !== 3'b000) $display("FAIL rmid_async: mv/busy/t1 got %b want 000", {m_tvalid, busy, s1_tready}); else n_pass++;
    n_checks++; if (m_tdata !== 8'h00) $display("FAIL rmid_tdata: got %h want 00", m_tdata); else n_pass++;
    do_reset();
    n_checks++; if (pkt_cnt1 !== 16'd0) $display("FAIL rmid_no_count: got %0d want 0", pkt_cnt1); else n_pass++;
    m_tready = 1'b1;
    q0.push_back(mk(8'hF1, 1'b1));
    q1.push_back(mk(8'hE5, 1'b1));
    exp_b = '{mk(8'hF1, 1'b1), mk(8'hE5, 1'b1)};
    wait_drain("rmid", 40);
    foreach (exp_b[i]) begin
      n_checks++;
      if (i >= out_q.size()) $display("FAIL rmid_beat%0d: missing, want %h/%b", i, exp_b[i].data, exp_b[i].last);
      else if (out_q[i] !== exp_b[i]) $display("FAIL rmid_beat%0d: got %h/%b want %h/%b", i, out_q[i].data, out_q[i].last, exp_b[i].data, exp_b[i].last);
      else n_pass++;
    end
    n_checks++; if ({pkt_cnt0, pkt_cnt1} !== {16'd1, 16'd1}) $display("FAIL rmid_pkt_cnt: got %0d/%0d want 1/1", pkt_cnt0, pkt_cnt1); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    m_tready = 1'b1;
    @(negedge clk); #1;
    // Deposit stands in for 65534 completed s0 packets.
    dut.pkt_cnt0_reg = 16'hFFFE;
    q0.push_back(mk(8'h5A, 1'b1));
    wait_drain("wrap1", 30);
    n_checks++; if (pkt_cnt0 !== 16'hFFFF) $display("FAIL wrap_ffff: got %h want ffff", pkt_cnt0); else n_pass++;
    q0.push_back(mk(8'h5B, 1'b1));
    wait_drain("wrap2", 30);
    n_checks++; if (pkt_cnt0 !== 16'h0000) $display("FAIL wrap_zero: got %h want 0000", pkt_cnt0); else n_pass++;
    n_checks++; if (pkt_cnt1 !== 16'h0000) $display("FAIL wrap_cnt1: got %h want 0000", pkt_cnt1); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_backpressure();
    test_oversize();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 ns, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axis_rr_arb_2_1.md
AXIS_RR_ARB_2_1 -- requirements
Module: axis_rr_arb_2_1

Interface
REQ-001 DATA_W, 8, data width of every tdata port.
REQ-002 MAX_BEATS, 256, maximum beats per packet before forced termination (2..65535).
REQ-003 clk  input  1  clock, all logic rising-edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 s0_tdata / s1_tdata  input  DATA_W  requester 0/1 payload.
REQ-006 s0_tvalid / s1_tvalid  input  1  requester 0/1 beat valid.
REQ-007 s0_tlast / s1_tlast  input  1  requester 0/1 last beat of packet.
REQ-008 s0_tready / s1_tready  output  1  requester 0/1 beat accepted when high with tvalid.
REQ-009 m_tdata  output  DATA_W  registered output payload.
REQ-010 m_tvalid  output  1  registered output valid.
REQ-011 m_tlast  output  1  registered output last.
REQ-012 m_tready  input  1  downstream ready.
REQ-013 sel  output  1  current/last grant, 0=s0, 1=s1.
REQ-014 busy  output  1  high while a packet is in progress (state not IDLE).
REQ-015 pkt_cnt0 / pkt_cnt1  output  16  completed packets per requester, wrap at 0xFFFF->0.
REQ-016 err_oversize  output  1  sticky, packet hit MAX_BEATS without tlast.

Function
REQ-017 FSM states: IDLE, GRANT0, GRANT1; reset state IDLE.
REQ-018 IDLE: only s0_tvalid -> GRANT0; only s1_tvalid -> GRANT1; both -> requester opposite to rr_ptr; neither -> stay.
REQ-019 rr_ptr holds the last-granted requester; reset value 1, so s0 wins the first contention.
REQ-020 sel updates on the IDLE->GRANTx transition and holds in IDLE.
REQ-021 sx_tready = (state==GRANTx) && (!m_tvalid || m_tready); the non-granted tready is 0; both treadys are 0 in IDLE.
REQ-022 Accepted beat (sx_tvalid && sx_tready) loads m_tdata/m_tlast and sets m_tvalid on the next edge.
REQ-023 m_tvalid clears on an edge with m_tready high and no new beat accepted.
REQ-024 m_tdata/m_tlast are stable while m_tvalid && !m_tready.
REQ-025 Latency: IDLE with tvalid -> grant at edge 1 -> first beat accepted in that cycle -> m_tvalid at edge 2.
REQ-026 beat_cnt (16-bit) counts accepted beats of the current packet and clears on packet end.
REQ-027 Packet end: accepted beat with tlast=1, or accepted beat with beat_cnt==MAX_BEATS-1.
REQ-028 On packet end: the state returns to IDLE, rr_ptr is set to the granted requester, and pkt_cntx increments.
REQ-029 A forced end (MAX_BEATS reached, tlast=0) drives m_tlast=1 on that beat and sets err_oversize; the remaining beats of the source form a new packet.
REQ-030 The cycle after a packet end is IDLE (one arbitration bubble); back-to-back packets alternate when both requesters are valid.
REQ-031 tvalid dropping mid-packet holds the grant; no switch occurs before packet end.
REQ-032 The arbiter never interleaves beats of two packets on m_*.

Reset
REQ-033 Reset is asynchronous, active-high, and applies immediately: state=IDLE, rr_ptr=1, sel=0, m_tvalid=0, m_tdata=0, m_tlast=0, beat_cnt=0, pkt_cnt0/1=0, err_oversize=0, treadys=0.
REQ-034 Reset mid-packet discards the in-flight output beat and partial packet without counting it.

Structure
REQ-035 The FSM state encoding and the default MAX_BEATS constant reside in shared package axis_pkg.
REQ-036 One sub-module, axis_out_reg (DATA_W register slice implementing REQ-022..024), is instantiated once.
REQ-037 The payload path is a 2:1 select on sel feeding axis_out_reg; there are no other datapath storage elements.

Verification
REQ-038 s0 sends 3 beats 0x11,0x22,0x33 (tlast on 0x33), m_tready=1 -> m_* shows the same 3 beats, m_tlast on 0x33, pkt_cnt0=1, sel=0.
REQ-039 s0 and s1 both valid with 2-beat packets, repeated 4 times -> output order s0,s1,s0,s1; pkt_cnt0=pkt_cnt1=2.
REQ-040 m_tready held low 5 cycles mid-packet -> m_tdata stable, s0_tready=0 throughout, no beat lost or duplicated.
REQ-041 MAX_BEATS=4, s1 sends 6 beats with no tlast until beat 6 -> m_tlast on beat 4, err_oversize=1, pkt_cnt1=2.
REQ-042 Reset asserted while GRANT1 with m_tvalid=1 -> same cycle m_tvalid=0 and busy=0; after release, s0/s1 contention grants s0 first.
REQ-043 pkt_cnt0 preloaded by 65535 packets, one more sent -> pkt_cnt0=0.
